alu_issue_ctrl: RTL and testbench

//  Multi-cycle issue controller that drives the registered 8-bit ALU. It is the initiator side of the ALU op/flag interface.
//  - Accepts 16-bit instructions over a valid/ready handshake.
//  - Reads a 4x8 register file and drives ALUOp/Data1/Data2.
//  - Captures Result/Z/S/C/OF one cycle later, writes back, and holds the architectural flags.
//  - Resolves conditional branches from those flags.

---
 rtl/alu_ctrl_pkg.sv | 80 ++++++++
 rtl/alu_ctrl_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared decode types, opcode codes and helpers for the ALU issue controller.
// Pure definitions: no latency, no flow control.
package alu_ctrl_pkg;

  localparam int NREGS = 4;
  localparam int REG_W = 8;

  // ALU opcode space; codes 12..15 are undecodable for class 0.
  localparam logic [3:0] ALUOP_PD1 = 4'd0;
  localparam logic [3:0] ALUOP_PD2 = 4'd1;
  localparam logic [3:0] ALUOP_ADD = 4'd2;
  localparam logic [3:0] ALUOP_SUB = 4'd3;
  localparam logic [3:0] ALUOP_AND = 4'd4;
  localparam logic [3:0] ALUOP_OR  = 4'd5;
  localparam logic [3:0] ALUOP_XOR = 4'd6;
  localparam logic [3:0] ALUOP_NOT = 4'd7;
  localparam logic [3:0] ALUOP_SHL = 4'd8;
  localparam logic [3:0] ALUOP_SHR = 4'd9;
  localparam logic [3:0] ALUOP_ROL = 4'd10;
  localparam logic [3:0] ALUOP_ROR = 4'd11;

  localparam logic [3:0] OP_BZ   = 4'd0;
  localparam logic [3:0] OP_BNZ  = 4'd1;
  localparam logic [3:0] OP_BC   = 4'd2;
  localparam logic [3:0] OP_BNC  = 4'd3;
  localparam logic [3:0] OP_BS   = 4'd4;
  localparam logic [3:0] OP_BNS  = 4'd5;
  localparam logic [3:0] OP_BOF  = 4'd6;
  localparam logic [3:0] OP_BNOF = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd9;

  localparam int INST_CLASS_BIT  = 15;
  localparam int INST_OP_LSB     = 11;
  localparam int INST_IMMSEL_BIT = 10;
  localparam int INST_RD_LSB     = 8;
  localparam int INST_IMM_LSB    = 0;

  typedef struct packed {
    logic       cls;
    logic [3:0] op;
    logic       immsel;
    logic [1:0] rd;
    logic [7:0] imm;
  } inst_t;

  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic ov;
  } flags_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, CTRL} state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      ALUOP_PD1, ALUOP_PD2, ALUOP_ADD, ALUOP_SUB,
      ALUOP_AND, ALUOP_OR,  ALUOP_XOR, ALUOP_NOT,
      ALUOP_SHL, ALUOP_SHR, ALUOP_ROL, ALUOP_ROR: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic branch_cond(input logic [3:0] op, input flags_t f);
    case (op)
      OP_BZ:   return f.z;
      OP_BNZ:  return !f.z;
      OP_BC:   return f.c;
      OP_BNC:  return !f.c;
      OP_BS:   return f.s;
      OP_BNS:  return !f.s;
      OP_BOF:  return f.ov;
      OP_BNOF: return !f.ov;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4x8 register file: one write port, two read ports sampled on rd_en, one combinational debug read.
// Read data appears one edge after rd_en; no backpressure.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             wr_vld,
  input  logic [1:0]       wr_addr,
  input  logic [REG_W-1:0] wr_dat,
  input  logic             rd_vld,
  input  logic [1:0]       rd_addr_a,
  input  logic [1:0]       rd_addr_b,
  output logic [REG_W-1:0] rd_dat_a,
  output logic [REG_W-1:0] rd_dat_b,
  input  logic [1:0]       dbg_addr,
  output logic [REG_W-1:0] dbg_dat
);

  logic [REG_W-1:0] mem [NREGS];

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      rd_dat_a <= '0;
      rd_dat_b <= '0;
    end else begin
      if (wr_vld) mem[wr_addr] <= wr_dat;
      if (rd_vld) begin
        rd_dat_a <= mem[rd_addr_a];
        rd_dat_b <= mem[rd_addr_b];
      end
    end
  end

  assign dbg_dat = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the registered 8-bit ALU; optional retire counter under ALU_CTRL_RETIRE_CNT_EN.
// ALU op: writeback 2 edges after accept, 3 cycles per op; ready only in IDLE, caller holds valid+inst.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
  #(parameter int CNT_W = 16)
(
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_InstValid,
  output logic        o_InstReady,
  input  logic [15:0] i_Inst,
  output logic [3:0]  o_ALUOp,
  output logic [7:0]  o_Data1,
  output logic [7:0]  o_Data2,
  input  logic [7:0]  i_Result,
  input  logic        i_Z,
  input  logic        i_S,
  input  logic        i_C,
  input  logic        i_OF,
  output logic        o_Z,
  output logic        o_S,
  output logic        o_C,
  output logic        o_OF,
  output logic        o_BranchTaken,
  output logic [7:0]  o_BranchTarget,
  output logic        o_Illegal,
  input  logic [1:0]  i_DbgAddr,
  output logic [7:0]  o_DbgData
`ifdef ALU_CTRL_RETIRE_CNT_EN
  ,output logic [CNT_W-1:0] o_RetireCnt
`endif
);

  state_t     state;
  inst_t      dec;
  flags_t     flags;
  logic       accept;
  logic       alu_accept;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic       ldi_q;
  logic       alu_immsel_q;
  logic [7:0] alu_imm_q;
  logic       rf_wr_vld;
  logic [7:0] rf_wr_dat;
  logic [7:0] rf_rd_dat_a;
  logic [7:0] rf_rd_dat_b;

  always_comb begin
    dec.cls    = i_Inst[INST_CLASS_BIT];
    dec.op     = i_Inst[INST_OP_LSB +: 4];
    dec.immsel = i_Inst[INST_IMMSEL_BIT];
    dec.rd     = i_Inst[INST_RD_LSB +: 2];
    dec.imm    = i_Inst[INST_IMM_LSB +: 8];
  end

  assign o_InstReady = (state == IDLE);
  assign accept      = o_InstReady && i_InstValid;
  assign alu_accept  = accept && !dec.cls && is_alu_op(dec.op);

  // CAPTURE writes the ALU result, CTRL writes the LDI immediate.
  always_comb begin
    rf_wr_vld = 1'b0;
    rf_wr_dat = imm_q;
    if (state == CAPTURE) begin
      rf_wr_vld = 1'b1;
      rf_wr_dat = i_Result;
    end else if (state == CTRL && ldi_q) begin
      rf_wr_vld = 1'b1;
    end
  end

  alu_ctrl_regfile u_regfile (
    .i_CLK     (i_CLK),
    .i_RST_N   (i_RST_N),
    .wr_vld    (rf_wr_vld),
    .wr_addr   (rd_q),
    .wr_dat    (rf_wr_dat),
    .rd_vld    (alu_accept),
    .rd_addr_a (dec.rd),
    .rd_addr_b (dec.imm[1:0]),
    .rd_dat_a  (rf_rd_dat_a),
    .rd_dat_b  (rf_rd_dat_b),
    .dbg_addr  (i_DbgAddr),
    .dbg_dat   (o_DbgData)
  );

  assign o_Data1 = rf_rd_dat_a;
  assign o_Data2 = alu_immsel_q ? alu_imm_q : rf_rd_dat_b;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state          <= IDLE;
      flags          <= '0;
      o_ALUOp        <= ALUOP_PD1;
      rd_q           <= '0;
      imm_q          <= '0;
      ldi_q          <= 1'b0;
      alu_immsel_q   <= 1'b0;
      alu_imm_q      <= '0;
      o_BranchTaken  <= 1'b0;
      o_BranchTarget <= '0;
      o_Illegal      <= 1'b0;
    end else begin
      o_BranchTaken <= 1'b0;
      o_Illegal     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q  <= dec.rd;
            imm_q <= dec.imm;
            ldi_q <= dec.cls && (dec.op == OP_LDI);
            if (dec.cls) begin
              state <= CTRL;
              // Pulses are registered at accept so they line up with the CTRL cycle.
              if (dec.op <= OP_JMP) begin
                o_BranchTaken  <= branch_cond(dec.op, flags);
                o_BranchTarget <= dec.imm;
              end else if (dec.op != OP_LDI) begin
                o_Illegal <= 1'b1;
              end
            end else if (is_alu_op(dec.op)) begin
              state        <= ISSUE;
              o_ALUOp      <= dec.op;
              alu_immsel_q <= dec.immsel;
              alu_imm_q    <= dec.imm;
            end else begin
              o_Illegal <= 1'b1;
            end
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          flags.z  <= i_Z;
          flags.s  <= i_S;
          flags.c  <= i_C;
          flags.ov <= i_OF;
          state    <= IDLE;
        end
        CTRL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Z  = flags.z;
  assign o_S  = flags.s;
  assign o_C  = flags.c;
  assign o_OF = flags.ov;

`ifdef ALU_CTRL_RETIRE_CNT_EN
  logic ctl_retire_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      ctl_retire_q <= 1'b0;
      o_RetireCnt  <= '0;
    end else begin
      if (accept) ctl_retire_q <= dec.cls && (dec.op <= OP_LDI);
      if (state == CAPTURE || (state == CTRL && ctl_retire_q))
        o_RetireCnt <= o_RetireCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the registered ALU.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] inst = '0;
  logic        ready;
  logic [3:0]  aluop;
  logic [7:0]  d1, d2;
  logic [7:0]  alu_res = '0;
  logic        alu_z = 1'b0, alu_s = 1'b0, alu_c = 1'b0, alu_of = 1'b0;
  logic [8:0]  alu_w;
  logic        fz, fs, fc, fof, br, ill;
  logic [7:0]  tgt;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_dat;
`ifdef ALU_CTRL_RETIRE_CNT_EN
  logic [3:0]  retire_cnt;
`endif

  int total = 0;
  int bad = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(4)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_InstValid(valid), .o_InstReady(ready), .i_Inst(inst),
    .o_ALUOp(aluop), .o_Data1(d1), .o_Data2(d2),
    .i_Result(alu_res), .i_Z(alu_z), .i_S(alu_s), .i_C(alu_c), .i_OF(alu_of),
    .o_Z(fz), .o_S(fs), .o_C(fc), .o_OF(fof),
    .o_BranchTaken(br), .o_BranchTarget(tgt), .o_Illegal(ill),
    .i_DbgAddr(dbg_addr), .o_DbgData(dbg_dat)
`ifdef ALU_CTRL_RETIRE_CNT_EN
    , .o_RetireCnt(retire_cnt)
`endif
  );

  // Registered ALU: PD1/PD2/NOT and unknown codes leave its flags untouched.
  always @(posedge clk) begin
    case (aluop)
      ALUOP_ADD: begin
        alu_w = {1'b0, d1} + {1'b0, d2};
        alu_res <= alu_w[7:0]; alu_z <= (alu_w[7:0] == 8'h00); alu_s <= alu_w[7];
        alu_c <= alu_w[8]; alu_of <= (d1[7] == d2[7]) && (alu_w[7] != d1[7]);
      end
      ALUOP_SUB: begin
        alu_w = {1'b0, d1} - {1'b0, d2};
        alu_res <= alu_w[7:0]; alu_z <= (alu_w[7:0] == 8'h00); alu_s <= alu_w[7];
        alu_c <= alu_w[8]; alu_of <= (d1[7] != d2[7]) && (alu_w[7] != d1[7]);
      end
      ALUOP_PD2: alu_res <= d2;
      ALUOP_NOT: alu_res <= ~d1;
      default:   alu_res <= d1;
    endcase
  end

  function automatic logic [15:0] enc(input logic c, input logic [3:0] op, input logic is,
                                      input logic [1:0] rd, input logic [7:0] imm);
    return {c, op, is, rd, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with ready high; returns at the negedge where ready is high again.
  task automatic exec(input logic [15:0] ins, output int busy, output int br_n,
                      output logic [7:0] br_tgt, output int ill_n);
    int guard;
    busy = 0; br_n = 0; ill_n = 0; br_tgt = '0; guard = 0;
    chk("exec entry ready", {31'd0, ready}, 32'd1);
    inst = ins;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    while (1) begin
      if (br) begin br_n++; br_tgt = tgt; end
      if (ill) ill_n++;
      if (ready) break;
      busy++;
      guard++;
      if (guard > 8) begin
        chk("exec ready timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  ra;
    logic [7:0]  rv;
    logic [3:0]  flg;
    int          busy;
    int          br;
    logic [7:0]  tgt;
    int          ill;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  initial begin
    int busy, brn, illn, lows;
    logic [7:0] btgt;

    // flags column is {Z,S,C,OF}
    vt[0]  = '{enc(1, OP_LDI,    0, 1, 8'h7F), 2'd1, 8'h7F, 4'b0000, 1, 0, 8'h00, 0};
    vt[1]  = '{enc(0, ALUOP_ADD, 1, 1, 8'h01), 2'd1, 8'h80, 4'b0101, 2, 0, 8'h00, 0};
    vt[2]  = '{enc(1, OP_LDI,    0, 2, 8'hFF), 2'd2, 8'hFF, 4'b0101, 1, 0, 8'h00, 0};
    vt[3]  = '{enc(0, ALUOP_ADD, 1, 2, 8'h01), 2'd2, 8'h00, 4'b1010, 2, 0, 8'h00, 0};
    vt[4]  = '{enc(1, OP_BZ,     0, 0, 8'h3C), 2'd2, 8'h00, 4'b1010, 1, 1, 8'h3C, 0};
    vt[5]  = '{enc(1, OP_BNZ,    0, 0, 8'h10), 2'd2, 8'h00, 4'b1010, 1, 0, 8'h00, 0};
    vt[6]  = '{enc(1, OP_JMP,    0, 0, 8'hAA), 2'd2, 8'h00, 4'b1010, 1, 1, 8'hAA, 0};
    vt[7]  = '{enc(1, 4'd12,     0, 2, 8'h55), 2'd2, 8'h00, 4'b1010, 1, 0, 8'h00, 1};
    vt[8]  = '{enc(0, 4'd13,     1, 2, 8'h55), 2'd2, 8'h00, 4'b1010, 0, 0, 8'h00, 1};
    vt[9]  = '{enc(1, OP_BC,     0, 0, 8'h20), 2'd2, 8'h00, 4'b1010, 1, 1, 8'h20, 0};
    vt[10] = '{enc(1, OP_BNS,    0, 0, 8'h21), 2'd2, 8'h00, 4'b1010, 1, 1, 8'h21, 0};
    vt[11] = '{enc(1, OP_BOF,    0, 0, 8'h22), 2'd2, 8'h00, 4'b1010, 1, 0, 8'h00, 0};
    vt[12] = '{enc(1, OP_LDI,    0, 0, 8'h80), 2'd0, 8'h80, 4'b1010, 1, 0, 8'h00, 0};
    vt[13] = '{enc(0, ALUOP_SUB, 0, 0, 8'h01), 2'd0, 8'h00, 4'b1000, 2, 0, 8'h00, 0};
    vt[14] = '{enc(0, ALUOP_ADD, 0, 3, 8'h01), 2'd3, 8'h80, 4'b0100, 2, 0, 8'h00, 0};
    vt[15] = '{enc(1, OP_BS,     0, 0, 8'h30), 2'd3, 8'h80, 4'b0100, 1, 1, 8'h30, 0};
    vt[16] = '{enc(1, OP_BNC,    0, 0, 8'h31), 2'd3, 8'h80, 4'b0100, 1, 1, 8'h31, 0};
    vt[17] = '{enc(0, ALUOP_SUB, 1, 3, 8'h01), 2'd3, 8'h7F, 4'b0001, 2, 0, 8'h00, 0};
    vt[18] = '{enc(1, OP_BNOF,   0, 0, 8'h40), 2'd3, 8'h7F, 4'b0001, 1, 0, 8'h00, 0};
    vt[19] = '{enc(1, 4'd15,     0, 3, 8'h11), 2'd3, 8'h7F, 4'b0001, 1, 0, 8'h00, 1};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst aluop", {28'd0, aluop}, {28'd0, ALUOP_PD1});
    chk("rst data1", {24'd0, d1}, 32'd0);
    chk("rst data2", {24'd0, d2}, 32'd0);
    chk("rst flags", {28'd0, fz, fs, fc, fof}, 32'd0);
    chk("rst pulses", {30'd0, br, ill}, 32'd0);
    chk("rst target", {24'd0, tgt}, 32'd0);
    rst_n = 1'b1;

    // Reset lands while ADD R0,#5 is in CAPTURE: no writeback
    dbg_addr = 2'd0;
    inst = enc(0, ALUOP_ADD, 1, 0, 8'h05);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("issue aluop", {28'd0, aluop}, {28'd0, ALUOP_ADD});
    chk("issue data2", {24'd0, d2}, 32'h05);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst R0", {24'd0, dbg_dat}, 32'd0);
    chk("midrst flags", {28'd0, fz, fs, fc, fof}, 32'd0);
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst aluop", {28'd0, aluop}, {28'd0, ALUOP_PD1});

    for (int i = 0; i < NV; i++) begin
      dbg_addr = vt[i].ra;
      exec(vt[i].ins, busy, brn, btgt, illn);
      if (vt[i].ill == 0) exp_retire++;
      chk($sformatf("v%0d busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d branch", i), brn, vt[i].br);
      if (vt[i].br != 0) chk($sformatf("v%0d target", i), {24'd0, btgt}, {24'd0, vt[i].tgt});
      chk($sformatf("v%0d illegal", i), illn, vt[i].ill);
      chk($sformatf("v%0d reg", i), {24'd0, dbg_dat}, {24'd0, vt[i].rv});
      chk($sformatf("v%0d flags", i), {28'd0, fz, fs, fc, fof}, {28'd0, vt[i].flg});
`ifdef ALU_CTRL_RETIRE_CNT_EN
      chk($sformatf("v%0d retire", i), {28'd0, retire_cnt}, exp_retire % 16);
`endif
    end

    // Valid held high across back-to-back ADD R0,#3 then SUB R0,R0
    dbg_addr = 2'd0;
    inst = enc(0, ALUOP_ADD, 1, 0, 8'h03);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inst = enc(0, ALUOP_SUB, 0, 0, 8'h00);
    lows = 0;
    while (!ready && lows < 10) begin lows++; @(negedge clk); end
    chk("b2b add ready-low", lows, 2);
    chk("b2b add R0", {24'd0, dbg_dat}, 32'h03);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    lows = 0;
    while (!ready && lows < 10) begin lows++; @(negedge clk); end
    exp_retire += 2;
    chk("b2b sub ready-low", lows, 2);
    chk("b2b sub R0", {24'd0, dbg_dat}, 32'h00);
    chk("b2b sub flags", {28'd0, fz, fs, fc, fof}, 32'b1000);

    // Writeback lands exactly on the second edge after accept
    dbg_addr = 2'd1;
    exec(enc(1, OP_LDI, 0, 1, 8'h7F), busy, brn, btgt, illn);
    exp_retire++;
    inst = enc(0, ALUOP_ADD, 1, 1, 8'h01);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("lat data1", {24'd0, d1}, 32'h7F);
    chk("lat data2", {24'd0, d2}, 32'h01);
    chk("lat edge1 R1", {24'd0, dbg_dat}, 32'h7F);
    @(negedge clk);
    chk("lat edge2 R1 old", {24'd0, dbg_dat}, 32'h7F);
    @(negedge clk);
    exp_retire++;
    chk("lat edge3 R1 new", {24'd0, dbg_dat}, 32'h80);
    chk("lat flags", {28'd0, fz, fs, fc, fof}, 32'b0101);
    chk("lat ready", {31'd0, ready}, 32'd1);
`ifdef ALU_CTRL_RETIRE_CNT_EN
    chk("final retire", {28'd0, retire_cnt}, exp_retire % 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
